// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and partial-product recoding.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS_M,
        PP_POS_2M,
        PP_NEG_M,
        PP_NEG_2M
    } recode_t;

    // Modified Booth recoding of {q[1], q[0], q[-1]} into one of five partial-product selections.
    function automatic recode_t booth_r4_recode(input logic [2:0] triplet);
        recode_t r;
        case (triplet)
            3'b001, 3'b010: r = PP_POS_M;
            3'b011:         r = PP_POS_2M;
            3'b100:         r = PP_NEG_2M;
            3'b101, 3'b110: r = PP_NEG_M;
            default:        r = PP_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Operand/product handshake bundle between operand registers and the result consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the product side.
interface booth_radix4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    // Producer of operands / consumer of products.
    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_r4_pp_sel.sv
// Partial-product mux: turns a Booth recode selection and the extended multiplicand into 0, +-M or +-2M.
// Latency: purely combinational.
// Backpressure: none.
module booth_r4_pp_sel
    import booth_pkg::*;
#(
    parameter int AW = 18
) (
    input  recode_t         sel,
    input  logic [AW-1:0]   m,
    output logic [AW-1:0]   pp
);

    logic [AW-1:0] m_x2;

    assign m_x2 = {m[AW-2:0], 1'b0};

    // Select the partial product; negation is plain two's complement in the accumulator width.
    always_comb begin
        pp = '0;
        case (sel)
            PP_POS_M:  pp = m;
            PP_POS_2M: pp = m_x2;
            PP_NEG_M:  pp = -m;
            PP_NEG_2M: pp = -m_x2;
            default:   pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, two multiplier bits retired per clock.
// Latency: out_valid rises ITER edges after the accepting edge (ITER = WIDTH/2, or WIDTH/2+1 unsigned).
// Backpressure: one job in flight; in_ready low in RUN/DONE, product held in DONE until out_ready.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    booth_radix4_multiplier_if.slave bus
);

    // Accumulator carries two guard bits so that +-2M never overflows.
    localparam int AW   = WIDTH + 2;
    // Unsigned operands get two zero bits above Q so the top recode triplet sees a positive number.
    localparam int QW   = SIGNED ? WIDTH : WIDTH + 2;
    localparam int ITER = QW / 2;
    localparam int CW   = $clog2(ITER);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end

    state_t          state;
    logic [AW-1:0]   a_reg;
    logic [QW-1:0]   q_reg;
    logic            q_m1;
    logic [AW-1:0]   m_reg;
    logic [CW-1:0]   count;
    logic            in_ready_r;
    logic            out_valid_r;

    recode_t         recode;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   sum;
    logic signed [AW+QW:0] cat;
    logic signed [AW+QW:0] cat_sh;
    logic [AW-1:0]   a_next;
    logic [QW-1:0]   q_next;
    logic            q_m1_next;

    logic            ext_bit;
    logic [AW-1:0]   m_load;
    logic [QW-1:0]   q_load;

    assign ext_bit = SIGNED ? bus.multiplicand[WIDTH-1] : 1'b0;
    assign m_load  = {{2{ext_bit}}, bus.multiplicand};
    assign q_load  = QW'(bus.multiplier);

    assign recode = booth_r4_recode({q_reg[1:0], q_m1});

    booth_r4_pp_sel #(
        .AW (AW)
    ) u_pp_sel (
        .sel (recode),
        .m   (m_reg),
        .pp  (pp)
    );

    assign sum       = a_reg + pp;
    assign cat       = {sum, q_reg, q_m1};
    assign cat_sh    = cat >>> 2;
    assign a_next    = cat_sh[AW+QW:QW+1];
    assign q_next    = cat_sh[QW:1];
    assign q_m1_next = cat_sh[0];

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    // Low 2*WIDTH bits of {A,Q}; straight from registers, so stable while DONE is held.
    assign bus.product   = {a_reg[2*WIDTH-QW-1:0], q_reg};

    // Control FSM plus datapath registers; handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_reg       <= '0;
            q_reg       <= '0;
            q_m1        <= 1'b0;
            m_reg       <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= '0;
                        q_reg      <= q_load;
                        q_m1       <= 1'b0;
                        m_reg      <= m_load;
                        count      <= CW'(ITER - 1);
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    if (count == '0) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: directed vector table, backpressure/reset sequences, random operands vs arithmetic model.
// Latency: checks ITER-edge result latency for signed (8) and unsigned (9) 16-bit instances.
// Backpressure: exercises out_ready hold and dropped in_valid pulses.
module tb_booth_radix4_multiplier;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    booth_radix4_multiplier_if #(.WIDTH(16)) s_if ();
    booth_radix4_multiplier_if #(.WIDTH(16)) u_if ();

    booth_radix4_multiplier #(.WIDTH(16), .SIGNED(1'b1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    booth_radix4_multiplier #(.WIDTH(16), .SIGNED(1'b0)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    // Plain arithmetic product, truncated to 32 bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q, input bit sgn);
        longint p;
        if (sgn) p = longint'($signed(m)) * longint'($signed(q));
        else     p = longint'({48'b0, m}) * longint'({48'b0, q});
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full job on the signed instance: accept, wait, check latency and product, release.
    task automatic sop(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp, input string nm);
        int lat;
        chk({nm, "_in_ready"}, 64'(s_if.in_ready), 64'd1);
        s_if.multiplicand = m;
        s_if.multiplier   = q;
        s_if.in_valid     = 1'b1;
        step();
        s_if.in_valid = 1'b0;
        lat = 0;
        while (!s_if.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd8);
        chk({nm, "_product"}, 64'(s_if.product), 64'(exp));
        s_if.out_ready = 1'b1;
        step();
        s_if.out_ready = 1'b0;
        chk({nm, "_released"}, 64'({s_if.out_valid, s_if.in_ready}), 64'b01);
    endtask

    // Same for the unsigned instance (ITER is one larger).
    task automatic uop(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp, input string nm);
        int lat;
        chk({nm, "_in_ready"}, 64'(u_if.in_ready), 64'd1);
        u_if.multiplicand = m;
        u_if.multiplier   = q;
        u_if.in_valid     = 1'b1;
        step();
        u_if.in_valid = 1'b0;
        lat = 0;
        while (!u_if.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd9);
        chk({nm, "_product"}, 64'(u_if.product), 64'(exp));
        u_if.out_ready = 1'b1;
        step();
        u_if.out_ready = 1'b0;
        chk({nm, "_released"}, 64'({u_if.out_valid, u_if.in_ready}), 64'b01);
    endtask

    initial begin
        logic [15:0] rm;
        logic [15:0] rq;
        logic [31:0] bp_exp;
        int          n;
        int          ghost;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[2] = '{16'h7FFF, 16'h8000, 32'hC000_8000};
        vecs[3] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
        vecs[4] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[5] = '{16'h8000, 16'h7FFF, 32'hC000_8000};

        rst = 1'b1;
        s_if.in_valid = 1'b0; s_if.out_ready = 1'b0;
        s_if.multiplicand = '0; s_if.multiplier = '0;
        u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
        u_if.multiplicand = '0; u_if.multiplier = '0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("reset_in_ready",  64'(s_if.in_ready),  64'd1);
        chk("reset_out_valid", 64'(s_if.out_valid), 64'd0);
        chk("reset_product",   64'(s_if.product),   64'd0);
        chk("reset_u_state",   64'({u_if.in_ready, u_if.out_valid, u_if.product}), {31'd0, 1'b1, 1'b0, 32'd0});

        for (int i = 0; i < 6; i++) begin
            sop(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: dropped in_valid during RUN and DONE, product held for 5 cycles.
        bp_exp = ref_mul(16'h1234, 16'h0567, 1'b1);
        s_if.multiplicand = 16'h1234;
        s_if.multiplier   = 16'h0567;
        s_if.in_valid     = 1'b1;
        step();
        s_if.in_valid = 1'b0;
        step();
        step();
        chk("bp_run_in_ready", 64'(s_if.in_ready), 64'd0);
        s_if.multiplicand = 16'h7777;
        s_if.multiplier   = 16'h3333;
        s_if.in_valid     = 1'b1;
        step();
        s_if.in_valid = 1'b0;
        n = 0;
        while (!s_if.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp_done_reached", 64'(s_if.out_valid), 64'd1);
        chk("bp_product", 64'(s_if.product), 64'(bp_exp));
        for (int i = 0; i < 5; i++) begin
            s_if.multiplicand = 16'(i + 9);
            s_if.multiplier   = 16'h0101;
            s_if.in_valid     = 1'b1;
            step();
            chk($sformatf("bp_hold%0d", i), 64'({s_if.out_valid, s_if.in_ready, s_if.product}),
                {30'd0, 1'b1, 1'b0, bp_exp});
        end
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        step();
        s_if.out_ready = 1'b0;
        chk("bp_release", 64'({s_if.out_valid, s_if.in_ready}), 64'b01);
        ghost = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_if.out_valid || !s_if.in_ready) ghost++;
        end
        chk("bp_no_ghost_job", 64'(ghost), 64'd0);

        // Reset sampled on the third RUN edge aborts the job.
        s_if.multiplicand = 16'h4321;
        s_if.multiplier   = 16'h1111;
        s_if.in_valid     = 1'b1;
        step();
        s_if.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_state", 64'({s_if.in_ready, s_if.out_valid, s_if.product}), {30'd0, 1'b1, 1'b0, 32'd0});
        ghost = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_if.out_valid) ghost++;
        end
        chk("rst_no_result", 64'(ghost), 64'd0);
        sop(16'h0007, 16'hFFFA, 32'hFFFF_FFD6, "post_rst");

        // Random signed operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            if (i == 0) rq = 16'h8000;
            if (i == 1) rm = 16'h7FFF;
            sop(rm, rq, ref_mul(rm, rq, 1'b1), $sformatf("rand_s%0d", i));
        end

        // Unsigned instance.
        uop(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "uns_max");
        uop(16'h8000, 16'h0002, 32'h0001_0000, "uns_msb");
        for (int i = 0; i < 10; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            uop(rm, rq, ref_mul(rm, rq, 1'b0), $sformatf("rand_u%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
